voice_alloc: RTL and testbench

//  Polyphonic voice allocator between the MIDI decoder (midi) and the oscillator stack.

---
 rtl/voice_alloc.sv | 171 +++++++++++++++++
 tb/tb_voice_alloc.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/voice_alloc.sv
// -----------------------------------------------------------------------------
// voice_alloc
//   Polyphonic voice allocator sitting between the MIDI decoder and the
//   oscillator stack. Each note-on is mapped to one of NUM_VOICES oscillator
//   slots; note-off releases the slot holding that note. An age rank per voice
//   (0 = newest assignment) identifies the oldest voice for stealing.
//
//   Optional feature macro: VOICE_STEAL_EN
//     defined   : note-on while all voices are gated steals the oldest voice
//     undefined : note-on while all voices are gated is dropped
//
// Ports
//   clk_i          in   system clock
//   nrst_i         in   synchronous active-low reset
//   note_i         in   note number, valid while a strobe is high
//   noteOnStrb_i   in   1-cycle note-on pulse
//   noteOffStrb_i  in   1-cycle note-off pulse
//   voiceNote_o    out  packed per-voice note, voice v at [v*NOTE_BITS +: NOTE_BITS]
//   voiceGate_o    out  per-voice gate (1 = sounding)
//   voiceTrig_o    out  per-voice 1-cycle pulse on (re)assignment
//   activeCount_o  out  number of gated voices
//   full_o         out  all voices gated
// -----------------------------------------------------------------------------
module voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_BITS  = 7
) (
    input  logic                            clk_i,
    input  logic                            nrst_i,
    input  logic [NOTE_BITS-1:0]            note_i,
    input  logic                            noteOnStrb_i,
    input  logic                            noteOffStrb_i,
    output logic [NUM_VOICES*NOTE_BITS-1:0] voiceNote_o,
    output logic [NUM_VOICES-1:0]           voiceGate_o,
    output logic [NUM_VOICES-1:0]           voiceTrig_o,
    output logic [$clog2(NUM_VOICES+1)-1:0] activeCount_o,
    output logic                            full_o
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    typedef logic [NOTE_BITS-1:0] note_t;
    typedef logic [IDX_W-1:0]     idx_t;

    note_t                  note_q [NUM_VOICES];
    note_t                  note_d [NUM_VOICES];
    idx_t                   rank_q [NUM_VOICES];
    idx_t                   rank_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]  gate_q, gate_d;
    logic [NUM_VOICES-1:0]  trig_q, trig_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   full_q, full_d;

    // Voice lookups on the current state.
    logic hit_found, free_found;
    idx_t hit_idx, free_idx, oldest_idx;

    always_comb begin
        hit_found  = 1'b0;
        free_found = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        oldest_idx = '0;
        // Scan high to low so the lowest-index free voice wins.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (gate_q[v] && note_q[v] == note_i) begin
                hit_found = 1'b1;
                hit_idx   = idx_t'(v);
            end
            if (!gate_q[v]) begin
                free_found = 1'b1;
                free_idx   = idx_t'(v);
            end
            if (rank_q[v] == idx_t'(NUM_VOICES - 1)) begin
                oldest_idx = idx_t'(v);
            end
        end
    end

    // Next-state computation.
    logic assign_en;
    idx_t assign_idx;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves a
        // variable unassigned and no latch is inferred.
        note_d     = note_q;
        rank_d     = rank_q;
        gate_d     = gate_q;
        trig_d     = '0;
        assign_en  = 1'b0;
        assign_idx = '0;

        if (noteOnStrb_i) begin
            if (hit_found) begin
                // Retrigger of an already sounding note: rank and trig only.
                assign_en  = 1'b1;
                assign_idx = hit_idx;
            end else if (free_found) begin
                assign_en  = 1'b1;
                assign_idx = free_idx;
                note_d[free_idx] = note_i;
                gate_d[free_idx] = 1'b1;
            end else begin
`ifdef VOICE_STEAL_EN
                // Full: reuse the oldest voice; gate stays high.
                assign_en  = 1'b1;
                assign_idx = oldest_idx;
                note_d[oldest_idx] = note_i;
`endif
            end
        end else if (noteOffStrb_i && hit_found) begin
            // Note stays on the output for the release tail.
            gate_d[hit_idx] = 1'b0;
        end

        if (assign_en) begin
            trig_d[assign_idx] = 1'b1;
            // Voices newer than the assigned one age by one; it becomes newest.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (rank_q[v] < rank_q[assign_idx]) begin
                    rank_d[v] = rank_q[v] + idx_t'(1);
                end
            end
            rank_d[assign_idx] = '0;
        end

        count_d = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            count_d = count_d + CNT_W'(gate_d[v]);
        end
        full_d = &gate_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            // NOTE: the per-voice note and rank arrays are reset explicitly;
            // the outputs and the rank permutation must be defined after reset.
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                rank_q[v] <= idx_t'(NUM_VOICES - 1 - v);
            end
            gate_q  <= '0;
            trig_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= note_d[v];
                rank_q[v] <= rank_d[v];
            end
            gate_q  <= gate_d;
            trig_q  <= trig_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note_out
        assign voiceNote_o[g*NOTE_BITS +: NOTE_BITS] = note_q[g];
    end

    assign voiceGate_o   = gate_q;
    assign voiceTrig_o   = trig_q;
    assign activeCount_o = count_q;
    assign full_o        = full_q;

endmodule

// File: tb/tb_voice_alloc.sv
// -----------------------------------------------------------------------------
// tb_voice_alloc
//   Directed self-checking bench for voice_alloc (NUM_VOICES=4, NOTE_BITS=7).
//   Inputs change on the falling edge; outputs are sampled on the falling edge
//   following the rising edge that captured the strobe.
// -----------------------------------------------------------------------------
module tb_voice_alloc;

    logic        clk_i = 1'b0;
    logic        nrst_i;
    logic [6:0]  note_i;
    logic        noteOnStrb_i;
    logic        noteOffStrb_i;
    logic [27:0] voiceNote_o;
    logic [3:0]  voiceGate_o;
    logic [3:0]  voiceTrig_o;
    logic [2:0]  activeCount_o;
    logic        full_o;

    int n_checks = 0;
    int n_fail   = 0;

    voice_alloc #(.NUM_VOICES(4), .NOTE_BITS(7)) dut (
        .clk_i         (clk_i),
        .nrst_i        (nrst_i),
        .note_i        (note_i),
        .noteOnStrb_i  (noteOnStrb_i),
        .noteOffStrb_i (noteOffStrb_i),
        .voiceNote_o   (voiceNote_o),
        .voiceGate_o   (voiceGate_o),
        .voiceTrig_o   (voiceTrig_o),
        .activeCount_o (activeCount_o),
        .full_o        (full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int n3, input int n2, input int n1, input int n0);
        return {4'b0, 7'(n3), 7'(n2), 7'(n1), 7'(n0)};
    endfunction

    // One strobe cycle; returns at the falling edge after the capturing edge.
    task automatic strobe(input logic on, input logic off, input int n);
        noteOnStrb_i  = on;
        noteOffStrb_i = off;
        note_i        = 7'(n);
        @(negedge clk_i);
        noteOnStrb_i  = 1'b0;
        noteOffStrb_i = 1'b0;
        note_i        = '0;
    endtask

    task automatic idle();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        nrst_i = 1'b0;
        @(negedge clk_i);
        nrst_i = 1'b1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] notes, input int gate,
                               input int trig, input int cnt, input int full);
        check({tag, ".note"},  32'(voiceNote_o),   notes);
        check({tag, ".gate"},  32'(voiceGate_o),   32'(gate));
        check({tag, ".trig"},  32'(voiceTrig_o),   32'(trig));
        check({tag, ".count"}, 32'(activeCount_o), 32'(cnt));
        check({tag, ".full"},  32'(full_o),        32'(full));
    endtask

    initial begin
        nrst_i        = 1'b0;
        note_i        = '0;
        noteOnStrb_i  = 1'b0;
        noteOffStrb_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        nrst_i = 1'b1;

        // 1: reset values, first allocation, one-cycle trig
        check_state("t1_reset", pk(0, 0, 0, 0), 'b0000, 'b0000, 0, 0);
        strobe(1, 0, 60);
        check_state("t1_on60", pk(0, 0, 0, 60), 'b0001, 'b0001, 1, 0);
        idle();
        check_state("t1_hold", pk(0, 0, 0, 60), 'b0001, 'b0000, 1, 0);

        // 2: note-off keeps note, clears gate
        do_reset();
        strobe(1, 0, 60);
        strobe(1, 0, 62);
        strobe(1, 0, 64);
        check_state("t2_three", pk(0, 64, 62, 60), 'b0111, 'b0100, 3, 0);
        strobe(0, 1, 62);
        check_state("t2_off62", pk(0, 64, 62, 60), 'b0101, 'b0000, 2, 0);

        // 3: full behaviour
        do_reset();
        strobe(1, 0, 60);
        strobe(1, 0, 62);
        strobe(1, 0, 64);
        strobe(1, 0, 65);
        check_state("t3_full", pk(65, 64, 62, 60), 'b1111, 'b1000, 4, 1);
        strobe(1, 0, 67);
`ifdef VOICE_STEAL_EN
        check_state("t3_steal67", pk(65, 64, 62, 67), 'b1111, 'b0001, 4, 1);
        // voice1 is now the oldest
        strobe(1, 0, 69);
        check_state("t3_steal69", pk(65, 64, 69, 67), 'b1111, 'b0010, 4, 1);
`else
        check_state("t3_drop67", pk(65, 64, 62, 60), 'b1111, 'b0000, 4, 1);
        strobe(0, 1, 67);
        check_state("t3_off67", pk(65, 64, 62, 60), 'b1111, 'b0000, 4, 1);
        strobe(0, 1, 62);
        check_state("t3_off62", pk(65, 64, 62, 60), 'b1101, 'b0000, 3, 0);
        strobe(1, 0, 67);
        check_state("t3_on67", pk(65, 64, 67, 60), 'b1111, 'b0010, 4, 1);
`endif

        // 4: retrigger of a held note
        do_reset();
        strobe(1, 0, 60);
        strobe(1, 0, 60);
        check_state("t4_retrig", pk(0, 0, 0, 60), 'b0001, 'b0001, 1, 0);
        strobe(1, 0, 62);
        strobe(1, 0, 60);
        check_state("t4_retrig2", pk(0, 0, 62, 60), 'b0011, 'b0001, 2, 0);

        // 5: both strobes -> note-on wins; stray note-off ignored
        strobe(1, 1, 70);
        check_state("t5_both", pk(0, 70, 62, 60), 'b0111, 'b0100, 3, 0);
        strobe(0, 1, 71);
        check_state("t5_off71", pk(0, 70, 62, 60), 'b0111, 'b0000, 3, 0);

        // 6: reset mid-operation
        strobe(1, 0, 72);
        check_state("t6_full", pk(72, 70, 62, 60), 'b1111, 'b1000, 4, 1);
        do_reset();
        check_state("t6_reset", pk(0, 0, 0, 0), 'b0000, 'b0000, 0, 0);
        strobe(1, 0, 50);
        check_state("t6_on50", pk(0, 0, 0, 50), 'b0001, 'b0001, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
